// File: rtl/data_memory_mem.sv
// rtl/data_memory_mem.sv - MEM-stage word RAM with read-modify-write sub-word stores and sign-extending loads
module data_memory_mem #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        stall_o,
  output logic        misaligned_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, MERGE} state_t;

  state_t                  state_q;
  logic [31:0]             mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [1:0]              lane_q;
  logic                    half_q;
  logic [15:0]             wbuf_q;
  logic [31:0]             rmw_word_q;
  logic [31:0]             rdata_q;
  logic                    rdata_valid_q;
  logic                    misaligned_q;

  logic [ADDR_WIDTH-1:0]   idx;
  logic                    is_byte, is_half, is_word, aligned, idle;
  logic                    store_word, store_sub, load_ok, req_mis;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_widx;
  logic [31:0]             ram_wdata;
  logic [31:0]             rd_word;
  logic [31:0]             merged;
  logic [31:0]             load_data;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic                    unused_addr;

  // Upper address bits wrap modulo the RAM depth and are deliberately dropped.
  assign unused_addr = ^addr_i[31:ADDR_WIDTH+2];

  assign idx     = addr_i[ADDR_WIDTH+1:2];
  assign is_byte = (size_i == 2'd1);
  assign is_half = (size_i == 2'd2);
  assign is_word = !is_byte && !is_half;
  assign aligned = is_byte || (is_half && !addr_i[0]) || (is_word && (addr_i[1:0] == 2'b00));
  assign idle    = (state_q == IDLE);

  // A write wins over a simultaneous read; the read is simply dropped.
  assign store_word = idle && mem_write_i && aligned && is_word;
  assign store_sub  = idle && mem_write_i && aligned && !is_word;
  assign load_ok    = idle && mem_read_i && !mem_write_i && aligned;
  assign req_mis    = idle && (mem_read_i || mem_write_i) && !aligned;

  assign stall_o = !reset && store_sub;

  assign rd_word = mem_q[idx];

  // Splice the latched sub-word into the word fetched during the IDLE cycle.
  always_comb begin
    merged = rmw_word_q;
    if (half_q) begin
      if (lane_q[1]) merged[31:16] = wbuf_q;
      else           merged[15:0]  = wbuf_q;
    end else begin
      merged[{lane_q, 3'b000} +: 8] = wbuf_q[7:0];
    end
  end

  // Lane extraction and sign extension for loads.
  always_comb begin
    rd_byte   = rd_word[{addr_i[1:0], 3'b000} +: 8];
    rd_half   = addr_i[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    if (is_byte)      load_data = {{24{rd_byte[7]}}, rd_byte};
    else if (is_half) load_data = {{16{rd_half[15]}}, rd_half};
  end

  // A merge write is suppressed whenever reset is asserted.
  assign ram_we    = !reset && (store_word || (state_q == MERGE));
  assign ram_widx  = (state_q == MERGE) ? idx_q : idx;
  assign ram_wdata = (state_q == MERGE) ? merged : wdata_i;

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_widx] <= ram_wdata;
  end

  // Control FSM, RMW capture registers and registered load/error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      lane_q        <= 2'b00;
      half_q        <= 1'b0;
      wbuf_q        <= 16'h0;
      rmw_word_q    <= 32'h0;
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_mis) begin
            misaligned_q <= 1'b1;
          end else if (store_sub) begin
            idx_q      <= idx;
            lane_q     <= addr_i[1:0];
            half_q     <= is_half;
            wbuf_q     <= is_half ? wdata_i[15:0] : {8'h00, wdata_i[7:0]};
            rmw_word_q <= rd_word;
            state_q    <= MERGE;
          end else if (load_ok) begin
            rdata_q       <= load_data;
            rdata_valid_q <= 1'b1;
          end
        end
        MERGE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign misaligned_o  = misaligned_q;

endmodule
